// File: rtl/game_sequencer.sv
// game_sequencer -- phase controller for a whack-a-mole game.
//
// Phases: IDLE -> COUNTDOWN -> PLAYING -> OVER. A start pulse from any phase
// restarts the countdown. A millisecond prescaler and a millisecond counter
// produce a one-second tick while COUNTDOWN or PLAYING is active.
//
// Ports
//   clk          in   system clock, all state changes on the rising edge
//   reset        in   asynchronous active-high reset
//   start        in   one-cycle start/restart pulse (highest priority)
//   mole_hit     in   one-cycle pulse per successful hit
//   mole_missed  in   one-cycle pulse per mole expiring unhit
//   state        out  phase: 00 IDLE, 01 COUNTDOWN, 10 PLAYING, 11 OVER
//   spawn_enable out  high only while PLAYING (gates mole timer/randomiser)
//   point        out  registered one-cycle pulse per accepted hit
//   clear_score  out  one-cycle pulse zeroing the external score counter
//   seconds_left out  remaining seconds of the current phase
//   misses       out  misses counted in the current game

module game_sequencer #(
    parameter int CLKS_PER_MS = 50000,
    parameter int COUNTDOWN_S = 3,
    parameter int GAME_S      = 60,
    parameter int MAX_MISSES  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mole_hit,
    input  logic       mole_missed,
    output logic [1:0] state,
    output logic       spawn_enable,
    output logic       point,
    output logic       clear_score,
    output logic [6:0] seconds_left,
    output logic [3:0] misses
);

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_COUNTDOWN = 2'b01;
    localparam logic [1:0] ST_PLAYING   = 2'b10;
    localparam logic [1:0] ST_OVER      = 2'b11;

    localparam int              PW         = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [9:0]      MS_LAST    = 10'd999;
    localparam logic [6:0]      CD_INIT    = 7'(COUNTDOWN_S);
    localparam logic [6:0]      GAME_INIT  = 7'(GAME_S);
    localparam logic [3:0]      MISS_LIMIT = 4'(MAX_MISSES);

    logic [PW-1:0] presc;
    logic [9:0]    ms_count;
    logic          running;
    logic          sec_tick;

    logic [1:0]    state_n;
    logic [6:0]    secs_n;
    logic [3:0]    misses_n;
    logic [3:0]    miss_inc;
    logic          phase_entry;

    assign running      = (state == ST_COUNTDOWN) || (state == ST_PLAYING);
    assign sec_tick     = running && (presc == PRESC_LAST) && (ms_count == MS_LAST);
    assign spawn_enable = (state == ST_PLAYING);

    // Saturating increment of the miss counter.
    assign miss_inc = (misses == 4'hF) ? misses : misses + 4'd1;

    always_comb begin
        state_n  = state;
        secs_n   = seconds_left;
        misses_n = misses;
        if (start) begin
            state_n  = ST_COUNTDOWN;
            secs_n   = CD_INIT;
            misses_n = '0;
        end else begin
            case (state)
                ST_COUNTDOWN: begin
                    if (sec_tick) begin
                        if (seconds_left == 7'd1) begin
                            state_n = ST_PLAYING;
                            secs_n  = GAME_INIT;
                        end else begin
                            secs_n = seconds_left - 7'd1;
                        end
                    end
                end
                ST_PLAYING: begin
                    // A miss and the final tick in the same cycle both take
                    // effect; either one alone is enough to end the game.
                    if (mole_missed) begin
                        misses_n = miss_inc;
                        if (miss_inc == MISS_LIMIT) begin
                            state_n = ST_OVER;
                        end
                    end
                    if (sec_tick) begin
                        if (seconds_left == 7'd1) begin
                            secs_n  = '0;
                            state_n = ST_OVER;
                        end else begin
                            secs_n = seconds_left - 7'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A start pulse counts as an entry even when already in COUNTDOWN.
    assign phase_entry = start || (state_n != state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            seconds_left <= '0;
            misses       <= '0;
            point        <= 1'b0;
            clear_score  <= 1'b0;
        end else begin
            state        <= state_n;
            seconds_left <= secs_n;
            misses       <= misses_n;
            point        <= (state == ST_PLAYING) && mole_hit && !start;
            clear_score  <= start;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            ms_count <= '0;
        end else if (phase_entry) begin
            presc    <= '0;
            ms_count <= '0;
        end else if (running) begin
            if (presc == PRESC_LAST) begin
                presc    <= '0;
                ms_count <= (ms_count == MS_LAST) ? '0 : ms_count + 10'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule
